// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and width helper for the shared-divider controller
package div_share_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/div_core.sv
// div_core: restoring unsigned divider iteration, one quotient bit per step
module div_core import div_share_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] q_nx_o,
  output logic [WIDTH-1:0] r_nx_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] a_q, b_q, rem_q, a_d, rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0] pr;
  logic ge;
  // one restoring step; quotient bits shift into the vacated dividend bits
  always_comb begin
    pr = {rem_q, a_q[WIDTH-1]};
    ge = pr >= {1'b0, b_q};
    rem_d = ge ? WIDTH'(pr - {1'b0, b_q}) : pr[WIDTH-1:0];
    a_d = {a_q[WIDTH-2:0], ge};
  end
  assign last_o = cnt_q == CNT_W'(WIDTH - 1);
  assign q_nx_o = a_d;
  assign r_nx_o = rem_d;
  assign count_o = cnt_q;
  // operand load, iteration and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      a_q <= a_i;
      b_q <= b_i;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      a_q <= a_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
    end else if (clr_i) begin
      cnt_q <= '0;
    end
  end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin arbiter + FSM sharing one iterative divider; DIV_SHARE_DZ_EN adds fast divide-by-zero path and rsp_dz
module div_share_ctrl import div_share_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = idx_w(N_REQ),
  localparam int CNT_W = idx_w(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_q,
  output logic [WIDTH-1:0]       rsp_r,
`ifdef DIV_SHARE_DZ_EN
  output logic                   rsp_dz,
`endif
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);
  state_e state_q;
  logic [ID_W-1:0] ptr_q, id_q, gnt_id, idx;
  logic [WIDTH-1:0] a_sel, b_sel, q_nx, r_nx, rsp_q_q, rsp_r_q;
  logic [ID_W-1:0] rsp_id_q;
  logic rsp_valid_q, accept, dz, last, run_last;
  int j;
  // round-robin search from ptr_q upward; the lowest offset with a request wins
  always_comb begin
    gnt_id = ptr_q;
    j = 0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      j = (j >= N_REQ) ? j - N_REQ : j;
      idx = ID_W'(j);
      if (req_valid[idx]) gnt_id = idx;
    end
  end
  assign accept = (state_q == IDLE) && (|req_valid);
  assign req_ready = accept ? N_REQ'(1) << gnt_id : '0;
  assign a_sel = req_a[gnt_id*WIDTH +: WIDTH];
  assign b_sel = req_b[gnt_id*WIDTH +: WIDTH];
  assign run_last = (state_q == RUN) && last;
`ifdef DIV_SHARE_DZ_EN
  assign dz = b_sel == '0;
  logic rsp_dz_q;
  // divide-by-zero flag is refreshed with every response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_dz_q <= 1'b0;
    else if ((accept && dz) || run_last) rsp_dz_q <= accept && dz;
  end
  assign rsp_dz = rsp_dz_q;
`else
  assign dz = 1'b0;
`endif
  div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .step_i  (state_q == RUN),
    .clr_i   (state_q == DONE),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .last_o  (last),
    .q_nx_o  (q_nx),
    .r_nx_o  (r_nx),
    .count_o (count)
  );
  // control FSM with registered response; response fields hold until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_q_q <= '0;
      rsp_r_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= dz ? DONE : RUN;
          ptr_q <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
          id_q <= gnt_id;
          if (dz) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q <= gnt_id;
            rsp_q_q <= '1;
            rsp_r_q <= a_sel;
          end
        end
        RUN: if (last) begin
          state_q <= DONE;
          rsp_valid_q <= 1'b1;
          rsp_id_q <= id_q;
          rsp_q_q <= q_nx;
          rsp_r_q <= r_nx;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_q = rsp_q_q;
  assign rsp_r = rsp_r_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: randomized + directed bench with a cycle-level behavioural model
module tb_div_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;
`ifdef DIV_SHARE_DZ_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic [N-1:0] req_valid, req_ready, hs, took;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_dz, busy;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_q, rsp_r;
  logic [3:0] count;
  int checks = 0, errors = 0, cyc = 0;
  int m_acc, m_lat, m_id, m_q, m_r, m_rr, h_q, h_r, h_id;
  bit m_in, m_dz, h_dz;
  int acc_port[$], acc_at[$];
  int n_rsp = 0, rsp_at, last_id, last_q, last_r, last_dz;

  div_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
`ifdef DIV_SHARE_DZ_EN
    .rsp_dz(rsp_dz),
`endif
    .busy(busy), .count(count)
  );
`ifndef DIV_SHARE_DZ_EN
  assign rsp_dz = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: one op in flight, latency WIDTH+1 (1 for fast dz), round-robin grant
  always @(negedge clk) begin
    int age, win, ia, ib, ec;
    bit act, ersp;
    logic [N-1:0] er;
    cyc++;
    hs = req_valid & req_ready;
    if (!rst_n) begin
      m_in = 0; m_rr = 0; h_q = 0; h_r = 0; h_id = 0; h_dz = 0;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_q", rsp_q, 0);
      chk("rst_r", rsp_r, 0);
      chk("rst_dz", rsp_dz, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
    end else begin
      for (int i = 0; i < N; i++) if (hs[i]) begin acc_port.push_back(i); acc_at.push_back(cyc); end
      if (rsp_valid) begin
        n_rsp++; rsp_at = cyc; last_id = rsp_id; last_q = rsp_q; last_r = rsp_r; last_dz = rsp_dz;
      end
      age = cyc - m_acc;
      act = m_in && age <= m_lat;
      ersp = act && age == m_lat;
      if (ersp) begin h_q = m_q; h_r = m_r; h_id = m_id; h_dz = m_dz; end
      win = -1;
      if (!act) for (int k = 0; k < N; k++) if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
      er = '0;
      if (win >= 0) er[win] = 1'b1;
      ec = act ? (m_dz ? 0 : age - 1) : 0;
      chk("rsp_valid", rsp_valid, ersp);
      chk("busy", busy, act);
      chk("count", count, ec);
      chk("req_ready", req_ready, er);
      chk("rsp_id", rsp_id, h_id);
      chk("rsp_q", rsp_q, h_q);
      chk("rsp_r", rsp_r, h_r);
      chk("rsp_dz", rsp_dz, h_dz);
      if (win >= 0) begin
        ia = req_a[win*W +: W];
        ib = req_b[win*W +: W];
        m_in = 1; m_acc = cyc; m_id = win;
        m_dz = DZ && ib == 0;
        m_lat = m_dz ? 1 : W + 1;
        m_q = ib == 0 ? (1 << W) - 1 : ia / ib;
        m_r = ib == 0 ? ia : ia % ib;
        m_rr = (win + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    took = hs;
    req_valid = req_valid & ~took;
  endtask

  task automatic put(input int p, input int a, input int b);
    req_a[p*W +: W] = W'(a);
    req_b[p*W +: W] = W'(b);
    req_valid[p] = 1'b1;
  endtask

  task automatic settle(input int bound);
    int n = 0;
    while ((req_valid != 0 || busy) && n < bound) begin step(); n++; end
    chk("settle_timeout", n >= bound, 0);
    step();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int rnd_b();
    return ($urandom_range(0, 7) == 0) ? 0 : ($urandom_range(0, 1) ? $urandom_range(1, 15) : $urandom_range(1, 255));
  endfunction

  initial begin
    int n0, g, nb;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; took = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    put(1, 100, 7);
    settle(40);
    chk("t1_id", last_id, 1);
    chk("t1_q", last_q, 14);
    chk("t1_r", last_r, 2);
    chk("t1_lat", rsp_at - acc_at[$], 9);
    do_reset();
    put(0, 50, 6); put(2, 90, 4);
    settle(60);
    chk("t2_first", acc_port[$-1], 0);
    chk("t2_second", acc_port[$], 2);
    chk("t2_gap", acc_at[$] - acc_at[$-1], 10);
    chk("t2_q", last_q, 22);
    chk("t2_r", last_r, 2);
    do_reset();
    n0 = acc_port.size();
    for (int p = 0; p < N; p++) put(p, $urandom_range(0, 255), rnd_b());
    g = 0;
    while (acc_port.size() < n0 + 8 && g < 200) begin
      step(); g++;
      for (int p = 0; p < N; p++) if (took[p]) put(p, $urandom_range(0, 255), rnd_b());
    end
    chk("t3_timeout", g >= 200, 0);
    for (int i = 0; i < 8; i++) chk("t3_order", acc_port[n0+i], i % 4);
    settle(200);
    put(0, 5, 9); settle(40);
    chk("t4a_q", last_q, 0);
    chk("t4a_r", last_r, 5);
    put(0, 255, 1); settle(40);
    chk("t4b_q", last_q, 255);
    chk("t4b_r", last_r, 0);
    put(2, 37, 0); settle(40);
    chk("t5_q", last_q, 255);
    chk("t5_r", last_r, 37);
    chk("t5_id", last_id, 2);
    chk("t5_dz", last_dz, DZ);
    chk("t5_lat", rsp_at - acc_at[$], DZ ? 1 : 9);
    do_reset();
    put(0, 200, 3);
    g = 0;
    do begin step(); g++; end while (!took[0] && g < 20);
    chk("t6_accept_timeout", g >= 20, 0);
    repeat (4) step();
    nb = n_rsp;
    @(posedge clk);
    #3 rst_n = 1'b0; req_valid = '0;
    #1;
    chk("t6_busy_now", busy, 0);
    chk("t6_count_now", count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) step();
    chk("t6_no_rsp", n_rsp, nb);
    put(3, 77, 5); settle(40);
    chk("t6_id", last_id, 3);
    chk("t6_q", last_q, 15);
    chk("t6_r", last_r, 2);
    for (int c = 0; c < 500; c++) begin
      step();
      for (int p = 0; p < N; p++)
        if (!req_valid[p] && $urandom_range(0, 3) == 0) put(p, $urandom_range(0, 255), rnd_b());
    end
    settle(300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Shared-divider controller: arbitrates N requesters onto a single iterative restoring unsigned divider, sequences it one quotient bit per clock, and returns quotient/remainder tagged with the requester index. Sits between the arithmetic clients and the one divider datapath, so the divider area is paid once. Valid/ready request side, single-cycle tagged response pulse.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/quotient/remainder width (4..32)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  divisors, same packing
- req_ready  out  N_REQ  one-hot accept strobe; request i taken on edge where req_valid[i] & req_ready[i]
- rsp_valid  out  1  one-cycle result pulse, no backpressure
- rsp_id  out  clog2(N_REQ)  index of requester owning the result
- rsp_q  out  WIDTH  quotient
- rsp_r  out  WIDTH  remainder
- rsp_dz  out  1  divide-by-zero flag (present only with DIV_SHARE_DZ_EN)
- busy  out  1  high from accept edge until rsp_valid cycle inclusive
- count  out  clog2(WIDTH+1)  quotient bits produced for current op; 0 in IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any req_valid, round-robin winner g gets req_ready[g]=1 combinationally; at that edge capture a, b, id=g; go RUN (or DONE, see dz). No req_valid → stay, req_ready=0.
- Round robin: pointer p resets to 0; search starts at p upward, wrapping; after grant to g, p = (g+1) mod N_REQ.
- RUN: one restoring step per cycle: partial remainder (WIDTH+1 bits) = {rem, next MSB of a}; if ≥ b, subtract, quotient bit 1, else 0. count increments per step; after WIDTH steps go DONE.
- DONE: rsp_valid=1, rsp_q/rsp_r/rsp_id driven; next state IDLE. rsp_q/rsp_r/rsp_id hold last values until next DONE.
- req_ready only asserted in IDLE; requester must hold valid and operands stable until accepted.
- b=0 without dz feature: normal run yields q=all ones, r=a.
- Reset (any time, incl. mid-RUN): in-flight op discarded, no response, pointer to 0.
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_q 0, rsp_r 0, rsp_dz 0, busy 0, count 0.

## Timing
- Accept edge E0; RUN occupies cycles after E0..E_WIDTH; rsp_valid high in cycle WIDTH+1 after E0 (9 cycles for WIDTH=8).
- Earliest next accept: edge at end of the cycle following rsp_valid; throughput one op per WIDTH+2 cycles.
- New req_valid arriving during RUN/DONE waits; no request lost while held.

## Configuration
- DIV_SHARE_DZ_EN defined: rsp_dz port exists; b=0 at accept skips RUN, DONE next cycle (rsp_valid 1 cycle after accept), q=all ones, r=a, rsp_dz=1; otherwise rsp_dz=0.
- Undefined: no rsp_dz port; b=0 runs full WIDTH cycles, same q/r values.

## Structure
- Package div_share_pkg: state enum (IDLE, RUN, DONE), helper for id/count widths.
- Sub-module div_core: WIDTH-parameterised restoring iteration (load, step, done, q, r, count); controller owns arbitration, FSM and response register.

## Test plan
- Single req on port 1: a=100, b=7 → rsp_valid 9 cycles after accept, rsp_id=1, q=14, r=2.
- Ports 0 and 2 request simultaneously, held → served 0 then 2, second accept exactly 10 cycles after first.
- All 4 request continuously for 8 ops → grant order 0,1,2,3,0,1,2,3.
- a=5,b=9 → q=0,r=5; a=255,b=1 → q=255,r=0.
- a=37,b=0 → q=255,r=37; with DIV_SHARE_DZ_EN rsp_dz=1 and latency 1, without latency 9.
- rst_n low at RUN step 4 → all outputs reset values immediately, no rsp_valid; post-reset request from port 3 completes correctly.
